// File: rtl/flags_reg_unit.sv
// Architectural NZCV flag register with split NZ/CV write enables and a one-entry
// shadow register used to preserve flags across interrupt entry and return.
module flags_reg_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stallE,
  input  logic       flushE,
  input  logic [1:0] FlagWriteE,
  input  logic       CondExE,
  input  logic [3:0] ALU_flags,
  output logic [3:0] flags_out,
  output logic [3:0] flags_next,
  input  logic       save_req,
  input  logic       restore_req,
  output logic       save_ack,
  output logic       restore_ack,
  output logic       shadow_valid,
  output logic [3:0] shadow_flags,
  output logic       seq_err
);

  typedef enum logic {StEmpty, StHeld} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_flags;
  logic [3:0] r_shadow;
  logic       r_save_ack;
  logic       r_restore_ack;
  logic       r_seq_err;

  logic       w_wr;
  logic       w_wr_nz;
  logic       w_wr_cv;
  logic [3:0] w_flags_next;
  logic       w_save_acc;
  logic       w_restore_acc;
  logic       w_seq_err_set;

  assign w_wr    = CondExE & ~stallE & ~flushE;
  assign w_wr_nz = w_wr & FlagWriteE[1];
  assign w_wr_cv = w_wr & FlagWriteE[0];

  assign w_flags_next = {w_wr_nz ? ALU_flags[3:2] : r_flags[3:2],
                         w_wr_cv ? ALU_flags[1:0] : r_flags[1:0]};

  always_comb begin
    w_state_next  = r_state;
    w_save_acc    = 1'b0;
    w_restore_acc = 1'b0;
    w_seq_err_set = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (save_req && !restore_req) begin
          w_save_acc   = 1'b1;
          w_state_next = StHeld;
        end else if (restore_req) begin
          w_seq_err_set = 1'b1;
        end
      end
      StHeld: begin
        if (restore_req && !save_req) begin
          w_restore_acc = 1'b1;
          w_state_next  = StEmpty;
        end else if (save_req) begin
          w_seq_err_set = 1'b1;
        end
      end
      default: w_state_next = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StEmpty;
      r_flags       <= RESET_FLAGS;
      r_shadow      <= 4'b0000;
      r_save_ack    <= 1'b0;
      r_restore_ack <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      // A restore overrides any execute-stage write landing on the same edge.
      r_flags       <= w_restore_acc ? r_shadow : w_flags_next;
      if (w_save_acc) begin
        r_shadow <= w_flags_next;
      end
      r_save_ack    <= w_save_acc;
      r_restore_ack <= w_restore_acc;
      r_seq_err     <= r_seq_err | w_seq_err_set;
    end
  end

  assign flags_out    = r_flags;
  assign flags_next   = w_flags_next;
  assign save_ack     = r_save_ack;
  assign restore_ack  = r_restore_ack;
  assign shadow_valid = (r_state == StHeld);
  assign shadow_flags = r_shadow;
  assign seq_err      = r_seq_err;

endmodule

// File: tb/tb_flags_reg_unit.sv
// Directed-vector bench: the driver pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_flags_reg_unit;

  logic       clk;
  logic       reset;
  logic       stallE;
  logic       flushE;
  logic [1:0] FlagWriteE;
  logic       CondExE;
  logic [3:0] ALU_flags;
  logic [3:0] flags_out;
  logic [3:0] flags_next;
  logic       save_req;
  logic       restore_req;
  logic       save_ack;
  logic       restore_ack;
  logic       shadow_valid;
  logic [3:0] shadow_flags;
  logic       seq_err;

  typedef struct {
    int         id;
    logic [3:0] flags;
    logic [3:0] nxt;
    logic       valid;
    logic [3:0] shadow;
    logic       sack;
    logic       rack;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  flags_reg_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stallE      (stallE),
    .flushE      (flushE),
    .FlagWriteE  (FlagWriteE),
    .CondExE     (CondExE),
    .ALU_flags   (ALU_flags),
    .flags_out   (flags_out),
    .flags_next  (flags_next),
    .save_req    (save_req),
    .restore_req (restore_req),
    .save_ack    (save_ack),
    .restore_ack (restore_ack),
    .shadow_valid(shadow_valid),
    .shadow_flags(shadow_flags),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare when an entry is queued.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("flags_out",    e.id, flags_out,             e.flags);
      chk("flags_next",   e.id, flags_next,            e.nxt);
      chk("shadow_valid", e.id, {3'b000, shadow_valid}, {3'b000, e.valid});
      chk("shadow_flags", e.id, shadow_flags,          e.shadow);
      chk("save_ack",     e.id, {3'b000, save_ack},    {3'b000, e.sack});
      chk("restore_ack",  e.id, {3'b000, restore_ack}, {3'b000, e.rack});
      chk("seq_err",      e.id, {3'b000, seq_err},     {3'b000, e.err});
    end
  end

  int step_id = 0;

  // Drive one cycle of inputs just after the edge; expected values describe what the
  // DUT shows during this cycle (registered state from prior edges, flags_next now).
  task automatic vec(input logic rst, input logic stall, input logic flush,
                     input logic [1:0] fw, input logic cond, input logic [3:0] alu,
                     input logic sv, input logic rs,
                     input logic [3:0] e_flags, input logic [3:0] e_next,
                     input logic e_valid, input logic [3:0] e_shadow,
                     input logic e_sack, input logic e_rack, input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    stallE      = stall;
    flushE      = flush;
    FlagWriteE  = fw;
    CondExE     = cond;
    ALU_flags   = alu;
    save_req    = sv;
    restore_req = rs;
    step_id++;
    e.id     = step_id;
    e.flags  = e_flags;
    e.nxt    = e_next;
    e.valid  = e_valid;
    e.shadow = e_shadow;
    e.sack   = e_sack;
    e.rack   = e_rack;
    e.err    = e_err;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; stallE = 1'b0; flushE = 1'b0; FlagWriteE = 2'b00; CondExE = 1'b0;
    ALU_flags = 4'b0000; save_req = 1'b0; restore_req = 1'b0;
    repeat (2) @(posedge clk);

    //  rst st fl fw    c  alu      sv rs | flags    next     V  shadow   sa ra er
    // Reset then full write
    vec(0, 0, 0, 2'b11, 1, 4'b1010, 0, 0, 4'b0000, 4'b1010, 0, 4'b0000, 0, 0, 0);
    // Split writes
    vec(0, 0, 0, 2'b01, 1, 4'b0101, 0, 0, 4'b1010, 4'b1001, 0, 4'b0000, 0, 0, 0);
    vec(0, 0, 0, 2'b10, 1, 4'b0111, 0, 0, 4'b1001, 4'b0101, 0, 4'b0000, 0, 0, 0);
    // Gating: cond fail, stall, flush, stall+flush
    vec(0, 0, 0, 2'b11, 0, 4'b1111, 0, 0, 4'b0101, 4'b0101, 0, 4'b0000, 0, 0, 0);
    vec(0, 1, 0, 2'b11, 1, 4'b1111, 0, 0, 4'b0101, 4'b0101, 0, 4'b0000, 0, 0, 0);
    vec(0, 0, 1, 2'b11, 1, 4'b1111, 0, 0, 4'b0101, 4'b0101, 0, 4'b0000, 0, 0, 0);
    vec(0, 1, 1, 2'b11, 1, 4'b1111, 0, 0, 4'b0101, 4'b0101, 0, 4'b0000, 0, 0, 0);
    // Save captures the post-write value
    vec(0, 0, 0, 2'b11, 1, 4'b0100, 0, 0, 4'b0101, 4'b0100, 0, 4'b0000, 0, 0, 0);
    vec(0, 0, 0, 2'b10, 1, 4'b1000, 1, 0, 4'b0100, 4'b1000, 0, 4'b0000, 0, 0, 0);
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 4'b1000, 4'b1000, 1, 4'b1000, 1, 0, 0);
    vec(0, 0, 0, 2'b11, 1, 4'b0001, 0, 0, 4'b1000, 4'b0001, 1, 4'b1000, 0, 0, 0);
    // Restore beats concurrent write
    vec(0, 0, 0, 2'b11, 1, 4'b1111, 0, 1, 4'b0001, 4'b1111, 1, 4'b1000, 0, 0, 0);
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 4'b1000, 4'b1000, 0, 4'b1000, 0, 1, 0);
    // Restore while empty
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 0, 1, 4'b1000, 4'b1000, 0, 4'b1000, 0, 0, 0);
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 4'b1000, 4'b1000, 0, 4'b1000, 0, 0, 1);
    vec(1, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 4'b1000, 4'b1000, 0, 4'b1000, 0, 0, 1);
    // Save, then save again with a concurrent write
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    vec(0, 0, 0, 2'b11, 1, 4'b0110, 1, 0, 4'b0000, 4'b0110, 1, 4'b0000, 1, 0, 0);
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 1, 1, 4'b0110, 4'b0110, 1, 4'b0000, 0, 0, 1);
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 4'b0110, 4'b0110, 1, 4'b0000, 0, 0, 1);
    // Reset alongside restore discards it
    vec(1, 0, 0, 2'b00, 0, 4'b0000, 0, 1, 4'b0110, 4'b0110, 1, 4'b0000, 0, 0, 1);
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Simultaneous save and restore while empty
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
    vec(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
